// File: rtl/reg_demux_if.sv
// Steering bus: one input word stream (with route select) and two output streams.
// master = producer/consumer side, slave = the demux.
interface reg_demux_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] in_dat;
    logic             in_vld;
    logic             in_sel;
    logic             in_rdy;
    logic [WIDTH-1:0] out1_dat;
    logic             out1_vld;
    logic             out1_rdy;
    logic [WIDTH-1:0] out2_dat;
    logic             out2_vld;
    logic             out2_rdy;

    modport master (
        output in_dat, in_vld, in_sel, out1_rdy, out2_rdy,
        input  in_rdy, out1_dat, out1_vld, out2_dat, out2_vld
    );

    modport slave (
        input  in_dat, in_vld, in_sel, out1_rdy, out2_rdy,
        output in_rdy, out1_dat, out1_vld, out2_dat, out2_vld
    );
endinterface

// File: rtl/reg_demux.sv
// Two-entry output buffer: head/tail registers tracked by an EMPTY/ONE/FULL state.
// Latency: pushed word is on o_dat one cycle later when it becomes head.
// Backpressure: o_full is purely registered; a push while FULL is never issued by the parent.
module reg_demux_fifo2 #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_dat,
    input  logic             i_rdy,
    output logic [WIDTH-1:0] o_dat,
    output logic             o_vld,
    output logic             o_full
);
    // Encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_tail;
    logic             w_pop;
    logic [1:0]       w_occ;

    assign w_pop  = (r_state != ST_EMPTY) && i_rdy;
    assign w_occ  = r_state;
    assign o_full = (w_occ == 2'(DEPTH));
    assign o_vld  = (r_state != ST_EMPTY);
    assign o_dat  = r_head;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_EMPTY;
            r_head  <= '0;
            r_tail  <= '0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (i_push) begin
                        r_head  <= i_dat;
                        r_state <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (i_push && w_pop) begin
                        r_head <= i_dat;
                    end else if (i_push) begin
                        r_tail  <= i_dat;
                        r_state <= ST_FULL;
                    end else if (w_pop) begin
                        r_state <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_pop) begin
                        r_head  <= r_tail;
                        r_state <= ST_ONE;
                    end
                end
                default: r_state <= ST_EMPTY;
            endcase
        end
    end
endmodule

// Steers each input word to output 1 (sel=1) or output 2 (sel=0), counting accepts per output.
// Latency: one cycle from accept to the word appearing at an empty (or draining) output.
// Backpressure: in_rdy follows registered fullness of the selected buffer only.
module reg_demux #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    reg_demux_if.slave  io_bus,
    input  logic        i_clr_cnt,
    output logic [15:0] o_cnt1,
    output logic [15:0] o_cnt2
);
    logic        r_rdy_en;
    logic [15:0] r_cnt1;
    logic [15:0] r_cnt2;
    logic        w_full1;
    logic        w_full2;
    logic        w_acc;
    logic        w_push1;
    logic        w_push2;

    // Holds in_rdy low until the first edge after reset release.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rdy_en <= 1'b0;
        end else begin
            r_rdy_en <= 1'b1;
        end
    end

    assign io_bus.in_rdy = r_rdy_en && (io_bus.in_sel ? !w_full1 : !w_full2);
    assign w_acc         = io_bus.in_vld && io_bus.in_rdy;
    assign w_push1       = w_acc && io_bus.in_sel;
    assign w_push2       = w_acc && !io_bus.in_sel;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt1 <= '0;
            r_cnt2 <= '0;
        end else if (i_clr_cnt) begin
            r_cnt1 <= '0;
            r_cnt2 <= '0;
        end else begin
            if (w_push1) r_cnt1 <= r_cnt1 + 16'd1;
            if (w_push2) r_cnt2 <= r_cnt2 + 16'd1;
        end
    end

    assign o_cnt1 = r_cnt1;
    assign o_cnt2 = r_cnt2;

    reg_demux_fifo2 #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_buf1 (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_push1),
        .i_dat   (io_bus.in_dat),
        .i_rdy   (io_bus.out1_rdy),
        .o_dat   (io_bus.out1_dat),
        .o_vld   (io_bus.out1_vld),
        .o_full  (w_full1)
    );

    reg_demux_fifo2 #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_buf2 (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_push2),
        .i_dat   (io_bus.in_dat),
        .i_rdy   (io_bus.out2_rdy),
        .o_dat   (io_bus.out2_dat),
        .o_vld   (io_bus.out2_vld),
        .o_full  (w_full2)
    );
endmodule

// File: tb/tb_reg_demux.sv
// Directed bench for reg_demux: routing, buffering, backpressure, counters and async reset.
module tb_reg_demux;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr_cnt = 1'b0;
    logic [15:0] cnt1;
    logic [15:0] cnt2;
    int          checks = 0;
    int          failures = 0;

    reg_demux_if #(.WIDTH(32)) bus ();

    reg_demux #(.WIDTH(32), .DEPTH(2)) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .io_bus    (bus.slave),
        .i_clr_cnt (clr_cnt),
        .o_cnt1    (cnt1),
        .o_cnt2    (cnt2)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #2;
        checks++; if (bus.out1_vld !== 1'b0) begin failures++; $display("FAIL reset_out1_vld got=%b exp=0", bus.out1_vld); end
        checks++; if (bus.out2_vld !== 1'b0) begin failures++; $display("FAIL reset_out2_vld got=%b exp=0", bus.out2_vld); end
        checks++; if (bus.out1_dat !== 32'h0) begin failures++; $display("FAIL reset_out1_dat got=%h exp=0", bus.out1_dat); end
        checks++; if (bus.out2_dat !== 32'h0) begin failures++; $display("FAIL reset_out2_dat got=%h exp=0", bus.out2_dat); end
        checks++; if (bus.in_rdy !== 1'b0) begin failures++; $display("FAIL reset_in_rdy got=%b exp=0", bus.in_rdy); end
        checks++; if (cnt1 !== 16'h0 || cnt2 !== 16'h0) begin failures++; $display("FAIL reset_cnt got=%h/%h exp=0/0", cnt1, cnt2); end
        tick();
        #2 rst_n = 1'b1;
        #1;
        checks++; if (bus.in_rdy !== 1'b0) begin failures++; $display("FAIL release_pre_edge_in_rdy got=%b exp=0", bus.in_rdy); end
        tick();
        checks++; if (bus.in_rdy !== 1'b1) begin failures++; $display("FAIL release_first_edge_in_rdy got=%b exp=1", bus.in_rdy); end
    endtask

    task automatic test_route;
        bus.in_sel = 1'b1; bus.in_dat = 32'hDEADBEEF; bus.in_vld = 1'b1;
        bus.out1_rdy = 1'b0; bus.out2_rdy = 1'b0;
        tick();
        bus.in_vld = 1'b0;
        checks++; if (bus.out1_vld !== 1'b1) begin failures++; $display("FAIL route_out1_vld got=%b exp=1", bus.out1_vld); end
        checks++; if (bus.out1_dat !== 32'hDEADBEEF) begin failures++; $display("FAIL route_out1_dat got=%h exp=deadbeef", bus.out1_dat); end
        checks++; if (bus.out2_vld !== 1'b0) begin failures++; $display("FAIL route_out2_vld got=%b exp=0", bus.out2_vld); end
        checks++; if (cnt1 !== 16'd1) begin failures++; $display("FAIL route_cnt1 got=%0d exp=1", cnt1); end
        bus.out1_rdy = 1'b1;
        tick();
        bus.out1_rdy = 1'b0;
        checks++; if (bus.out1_vld !== 1'b0) begin failures++; $display("FAIL route_drain_vld got=%b exp=0", bus.out1_vld); end
        checks++; if (bus.out1_dat !== 32'hDEADBEEF) begin failures++; $display("FAIL route_hold_dat got=%h exp=deadbeef", bus.out1_dat); end
    endtask

    task automatic test_full_backpressure;
        bus.in_sel = 1'b0; bus.in_vld = 1'b1; bus.out2_rdy = 1'b0;
        bus.in_dat = 32'h11; tick();
        bus.in_dat = 32'h22; tick();
        bus.in_dat = 32'h33;
        checks++; if (bus.in_rdy !== 1'b0) begin failures++; $display("FAIL bp_full_in_rdy got=%b exp=0", bus.in_rdy); end
        checks++; if (cnt2 !== 16'd2) begin failures++; $display("FAIL bp_cnt2 got=%0d exp=2", cnt2); end
        tick();
        checks++; if (cnt2 !== 16'd2) begin failures++; $display("FAIL bp_stall_cnt2 got=%0d exp=2", cnt2); end
        checks++; if (bus.out2_dat !== 32'h11 || bus.out2_vld !== 1'b1) begin failures++; $display("FAIL bp_stable_head got=%h/%b exp=11/1", bus.out2_dat, bus.out2_vld); end
        bus.out2_rdy = 1'b1;
        #1;
        checks++; if (bus.in_rdy !== 1'b0) begin failures++; $display("FAIL bp_no_comb_path got=%b exp=0", bus.in_rdy); end
        tick();
        checks++; if (bus.out2_dat !== 32'h22) begin failures++; $display("FAIL bp_order_second got=%h exp=22", bus.out2_dat); end
        checks++; if (bus.in_rdy !== 1'b1) begin failures++; $display("FAIL bp_after_pop_in_rdy got=%b exp=1", bus.in_rdy); end
        tick();
        bus.in_vld = 1'b0;
        checks++; if (bus.out2_dat !== 32'h33 || bus.out2_vld !== 1'b1) begin failures++; $display("FAIL bp_third_word got=%h/%b exp=33/1", bus.out2_dat, bus.out2_vld); end
        checks++; if (cnt2 !== 16'd3) begin failures++; $display("FAIL bp_cnt2_final got=%0d exp=3", cnt2); end
        tick();
        bus.out2_rdy = 1'b0;
        checks++; if (bus.out2_vld !== 1'b0) begin failures++; $display("FAIL bp_drained got=%b exp=0", bus.out2_vld); end
    endtask

    task automatic test_independence;
        bus.in_sel = 1'b1; bus.in_vld = 1'b1; bus.out1_rdy = 1'b0; bus.out2_rdy = 1'b0;
        bus.in_dat = 32'h100; tick();
        bus.in_dat = 32'h200; tick();
        checks++; if (bus.in_rdy !== 1'b0) begin failures++; $display("FAIL indep_buf1_full got=%b exp=0", bus.in_rdy); end
        bus.in_sel = 1'b0; bus.in_dat = 32'h5;
        #1;
        checks++; if (bus.in_rdy !== 1'b1) begin failures++; $display("FAIL indep_buf2_ready got=%b exp=1", bus.in_rdy); end
        tick();
        bus.in_vld = 1'b0;
        checks++; if (bus.out2_vld !== 1'b1 || bus.out2_dat !== 32'h5) begin failures++; $display("FAIL indep_out2 got=%b/%h exp=1/5", bus.out2_vld, bus.out2_dat); end
        checks++; if (bus.out1_vld !== 1'b1 || bus.out1_dat !== 32'h100) begin failures++; $display("FAIL indep_out1_unchanged got=%b/%h exp=1/100", bus.out1_vld, bus.out1_dat); end
        checks++; if (cnt1 !== 16'd3 || cnt2 !== 16'd4) begin failures++; $display("FAIL indep_cnt got=%0d/%0d exp=3/4", cnt1, cnt2); end
        bus.out1_rdy = 1'b1; bus.out2_rdy = 1'b1;
        tick();
        checks++; if (bus.out1_dat !== 32'h200 || bus.out2_vld !== 1'b0) begin failures++; $display("FAIL indep_drain1 got=%h/%b exp=200/0", bus.out1_dat, bus.out2_vld); end
        tick();
        bus.out1_rdy = 1'b0; bus.out2_rdy = 1'b0;
        checks++; if (bus.out1_vld !== 1'b0) begin failures++; $display("FAIL indep_drain2 got=%b exp=0", bus.out1_vld); end
    endtask

    task automatic test_push_pop;
        bus.in_sel = 1'b1; bus.in_vld = 1'b1; bus.out1_rdy = 1'b0;
        bus.in_dat = 32'hA; tick();
        bus.in_dat = 32'hB; bus.out1_rdy = 1'b1;
        #1;
        checks++; if (bus.in_rdy !== 1'b1) begin failures++; $display("FAIL pp_in_rdy got=%b exp=1", bus.in_rdy); end
        tick();
        bus.in_vld = 1'b0; bus.out1_rdy = 1'b0;
        checks++; if (bus.out1_dat !== 32'hB || bus.out1_vld !== 1'b1) begin failures++; $display("FAIL pp_head got=%h/%b exp=b/1", bus.out1_dat, bus.out1_vld); end
        checks++; if (cnt1 !== 16'd5) begin failures++; $display("FAIL pp_cnt1 got=%0d exp=5", cnt1); end
        bus.out1_rdy = 1'b1;
        tick();
        bus.out1_rdy = 1'b0;
        checks++; if (bus.out1_vld !== 1'b0) begin failures++; $display("FAIL pp_state_one got=%b exp=0", bus.out1_vld); end
    endtask

    task automatic test_counter;
        bus.in_sel = 1'b0; bus.in_vld = 1'b1; bus.out2_rdy = 1'b1; bus.in_dat = 32'h77;
        repeat (65531) tick();
        checks++; if (cnt2 !== 16'hFFFF) begin failures++; $display("FAIL cnt_reach_ffff got=%h exp=ffff", cnt2); end
        checks++; if (cnt1 !== 16'd5) begin failures++; $display("FAIL cnt1_untouched got=%0d exp=5", cnt1); end
        tick();
        checks++; if (cnt2 !== 16'h0000) begin failures++; $display("FAIL cnt_wrap got=%h exp=0000", cnt2); end
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        checks++; if (cnt1 !== 16'h0 || cnt2 !== 16'h0) begin failures++; $display("FAIL cnt_clr_override got=%h/%h exp=0/0", cnt1, cnt2); end
        tick();
        bus.in_vld = 1'b0;
        checks++; if (cnt2 !== 16'd1) begin failures++; $display("FAIL cnt_after_clr got=%0d exp=1", cnt2); end
        tick();
        bus.out2_rdy = 1'b0;
        checks++; if (bus.out2_vld !== 1'b0) begin failures++; $display("FAIL cnt_drain got=%b exp=0", bus.out2_vld); end
    endtask

    task automatic test_async_reset;
        bus.out1_rdy = 1'b0; bus.out2_rdy = 1'b0; bus.in_vld = 1'b1;
        bus.in_sel = 1'b1; bus.in_dat = 32'h1; tick();
        bus.in_dat = 32'h2; tick();
        bus.in_sel = 1'b0; bus.in_dat = 32'h3; tick();
        bus.in_dat = 32'h4; tick();
        bus.in_vld = 1'b0;
        checks++; if (bus.in_rdy !== 1'b0 || bus.out1_vld !== 1'b1 || bus.out2_vld !== 1'b1) begin failures++; $display("FAIL ar_both_full got=%b/%b/%b exp=0/1/1", bus.in_rdy, bus.out1_vld, bus.out2_vld); end
        checks++; if (cnt1 !== 16'd2 || cnt2 !== 16'd3) begin failures++; $display("FAIL ar_pre_cnt got=%0d/%0d exp=2/3", cnt1, cnt2); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.out1_vld !== 1'b0 || bus.out2_vld !== 1'b0) begin failures++; $display("FAIL ar_vld got=%b/%b exp=0/0", bus.out1_vld, bus.out2_vld); end
        checks++; if (bus.out1_dat !== 32'h0 || bus.out2_dat !== 32'h0) begin failures++; $display("FAIL ar_dat got=%h/%h exp=0/0", bus.out1_dat, bus.out2_dat); end
        checks++; if (bus.in_rdy !== 1'b0) begin failures++; $display("FAIL ar_in_rdy got=%b exp=0", bus.in_rdy); end
        checks++; if (cnt1 !== 16'h0 || cnt2 !== 16'h0) begin failures++; $display("FAIL ar_cnt got=%h/%h exp=0/0", cnt1, cnt2); end
        #2 rst_n = 1'b1;
        tick();
        checks++; if (bus.in_rdy !== 1'b1) begin failures++; $display("FAIL ar_release_in_rdy got=%b exp=1", bus.in_rdy); end
        checks++; if (bus.out1_vld !== 1'b0 || bus.out2_vld !== 1'b0) begin failures++; $display("FAIL ar_no_stale got=%b/%b exp=0/0", bus.out1_vld, bus.out2_vld); end
    endtask

    initial begin
        bus.in_dat = '0; bus.in_vld = 1'b0; bus.in_sel = 1'b1;
        bus.out1_rdy = 1'b0; bus.out2_rdy = 1'b0;
        test_reset();
        test_route();
        test_full_backpressure();
        test_independence();
        test_push_pop();
        test_counter();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/reg_demux.md
REG_DEMUX -- requirements
Module: reg_demux

Interface
REQ-001 Parameter: WIDTH, 32, data width of input and both outputs.
REQ-002 Parameter: DEPTH, 2, entries per output buffer; fixed at 2.
REQ-003 CLK  input  1  single clock, all state updates on rising edge.
REQ-004 RESETN  input  1  reset, asynchronous, active-low.
REQ-005 IN_DATA  input  WIDTH  word to be steered.
REQ-006 IN_VALID  input  1  IN_DATA valid this cycle.
REQ-007 SELECT  input  1  route select: 1 -> output 1, 0 -> output 2; sampled with IN_VALID.
REQ-008 IN_READY  output  1  block accepts the word this cycle.
REQ-009 OUT1_DATA  output  WIDTH  head word of buffer 1.
REQ-010 OUT1_VALID  output  1  buffer 1 non-empty.
REQ-011 OUT1_READY  input  1  consumer 1 takes the head word.
REQ-012 OUT2_DATA / OUT2_VALID / OUT2_READY: same as OUT1_*, for buffer 2.
REQ-013 CLR_CNT  input  1  synchronous clear of both transfer counters.
REQ-014 CNT1, CNT2  output  16 each  accepted-word counts per output.

Function
REQ-015 Accept: IN_VALID && IN_READY on a rising edge; the word is written to the buffer chosen by SELECT.
REQ-016 IN_READY SHALL be 1 only when the selected buffer holds fewer than 2 entries, derived from registered occupancy and SELECT only; no combinational path from OUTx_READY to IN_READY.
REQ-017 Each buffer is a 2-entry FIFO with states EMPTY, ONE, FULL; pop = OUTx_VALID && OUTx_READY.
REQ-018 Transitions: EMPTY-push->ONE; ONE-push->FULL; ONE-pop->EMPTY; ONE-push&pop->ONE (new word becomes head); FULL-pop->ONE; FULL never receives a push.
REQ-019 Latency: an accepted word appears on OUTx_DATA with OUTx_VALID=1 on the cycle after acceptance when the buffer was EMPTY or was ONE with a simultaneous pop.
REQ-020 Order SHALL be preserved per output; the two outputs are independent, and a stall on one output SHALL not block words routed to the other.
REQ-021 OUTx_VALID = (state != EMPTY); OUTx_DATA holds its last head value while EMPTY.
REQ-022 OUTx_DATA/OUTx_VALID SHALL be stable while OUTx_VALID=1 and OUTx_READY=0.
REQ-023 CNTx increments by 1 per word accepted into buffer x, wrapping 0xFFFF -> 0x0000.
REQ-024 CLR_CNT=1 sets both counters to 0 on the edge, overriding a simultaneous increment.
REQ-025 IN_VALID=0: no state change on the input side regardless of SELECT.

Reset
REQ-026 RESETN=0 SHALL immediately force both buffers EMPTY, OUTx_VALID=0, OUTx_DATA=0, CNTx=0, IN_READY=0, independent of CLK.
REQ-027 After RESETN rises, IN_READY SHALL be 1 from the first rising edge onward (buffers empty).
REQ-028 Reset asserted mid-transfer discards all buffered words; no partial word is ever presented.

Verification
REQ-029 Route: SELECT=1, IN_DATA=0xDEADBEEF accepted, OUT1_READY=0 -> next cycle OUT1_VALID=1, OUT1_DATA=0xDEADBEEF, OUT2_VALID=0, CNT1=1.
REQ-030 Full/backpressure: push 0x11, 0x22, 0x33 to output 2 with OUT2_READY=0 -> 0x11, 0x22 accepted, IN_READY=0 for 0x33; raise OUT2_READY -> 0x11 then 0x22 delivered in order, 0x33 accepted after the first pop.
REQ-031 Independence: buffer 1 FULL, OUT1_READY=0; SELECT=0, IN_DATA=0x5 -> accepted, OUT2_DATA=0x5 next cycle, buffer 1 unchanged.
REQ-032 Simultaneous push/pop: buffer 1 in ONE holding 0xA, push 0xB with OUT1_READY=1 -> next cycle OUT1_DATA=0xB, state ONE, CNT1 incremented.
REQ-033 Counter: CNT2=0xFFFF, accept one word to output 2 -> CNT2=0x0000; CLR_CNT=1 with a simultaneous accept -> counters 0.
REQ-034 Async reset: RESETN low between edges with both buffers FULL -> OUTx_VALID=0, IN_READY=0, CNTx=0 before the next edge.
